// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and FSM state encoding for mem_access_unit.
// Contents: WORD_SIZE (memory byte width), ADDR_W (byte address width),
//           DATA_W (CPU-side access width) and the sequencer state type.
package mem_pkg;

    localparam int WORD_SIZE = 8;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 2 * WORD_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: CPU request/response handshake plus 8-bit memory bus.
// Ports (signals):
//   req_valid/req_ready/req_write/req_wide/req_addr/req_wdata
//     CPU request with valid/ready handshake.
//   resp_valid/resp_rdata
//     one-cycle completion pulse and load data.
//   mem_addr/mem_wdata/mem_we/mem_rdata
//     byte-wide main memory; mem_rdata is a combinational read.
// Modports:
//   slave  = the access unit.
//   master = its environment (CPU plus main memory).
interface mem_access_unit_if;
    import mem_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic                 req_wide;
    logic [ADDR_W-1:0]    req_addr;
    logic [DATA_W-1:0]    req_wdata;

    logic                 resp_valid;
    logic [DATA_W-1:0]    resp_rdata;

    logic [ADDR_W-1:0]    mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_wide,
        input  req_addr,
        input  req_wdata,
        input  mem_rdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output mem_addr,
        output mem_wdata,
        output mem_we
    );

    modport master (
        output req_valid,
        output req_write,
        output req_wide,
        output req_addr,
        output req_wdata,
        output mem_rdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we
    );

endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: splits 8/16-bit CPU loads/stores into byte accesses
// on an 8-bit memory. 16-bit accesses are little-endian (low byte at addr).
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous, active-high
//   bus   - mem_access_unit_if.slave: request/response handshake and
//           the memory address/data/write-enable lines
module mem_access_unit
    import mem_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              write_q;
    logic              wide_q;

    logic              idle_ready;
    logic              accept;
    logic [ADDR_W-1:0] addr_hi;

    assign idle_ready = (state == IDLE) && !reset;
    assign accept     = bus.req_valid && idle_ready;

    // High byte address wraps naturally at the top of the address space.
    assign addr_hi    = addr_q + ADDR_W'(1);

    assign bus.req_ready  = idle_ready;
    assign bus.resp_rdata = reset ? '0 : rdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and memory-side outputs
    always_comb begin
        state_next     = state;
        bus.mem_addr   = addr_q;
        bus.mem_we     = 1'b0;
        bus.mem_wdata  = '0;
        bus.resp_valid = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = LO;
                end
            end
            LO: begin
                bus.mem_we = write_q;
                if (write_q) begin
                    bus.mem_wdata = wdata_q[WORD_SIZE-1:0];
                end
                state_next = wide_q ? HI : RESP;
            end
            HI: begin
                bus.mem_addr = addr_hi;
                bus.mem_we   = write_q;
                if (write_q) begin
                    bus.mem_wdata = wdata_q[DATA_W-1:WORD_SIZE];
                end
                state_next = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Reset silences the memory bus in the same cycle, so a
        // half-finished wide store never writes its high byte.
        if (reset) begin
            bus.mem_addr   = '0;
            bus.mem_we     = 1'b0;
            bus.mem_wdata  = '0;
            bus.resp_valid = 1'b0;
        end
    end

    // Request latches and load data assembly
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            wide_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        write_q <= bus.req_write;
                        wide_q  <= bus.req_wide;
                        // Stores report zero data.
                        if (bus.req_write) begin
                            rdata_q <= '0;
                        end
                    end
                end
                LO: begin
                    if (!write_q) begin
                        rdata_q[WORD_SIZE-1:0] <= bus.mem_rdata;
                        // Narrow loads are zero-extended.
                        if (!wide_q) begin
                            rdata_q[DATA_W-1:WORD_SIZE] <= '0;
                        end
                    end
                end
                HI: begin
                    if (!write_q) begin
                        rdata_q[DATA_W-1:WORD_SIZE] <= bus.mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench for mem_access_unit.
// Byte memory lives here; a byte-array reference model predicts results.
module tb_mem_access_unit;

    typedef struct packed {
        logic [15:0]      rd;
        logic [7:0]       lat;
        logic [1:0]       nw;
        logic [1:0][15:0] wa;
        logic [1:0][7:0]  wv;
    } obs_t;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];

    logic        pl_en   = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    logic [15:0] wr_a[$];
    logic [7:0]  wr_d[$];
    int          acc_cyc[$];

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.mem_we === 1'b1) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_we === 1'b1) begin
            wr_a.push_back(bus.mem_addr);
            wr_d.push_back(bus.mem_wdata);
        end
        if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) begin
            acc_cyc.push_back(cyc);
        end
    end

    // Reference: what a request should produce, from byte-array semantics.
    function automatic obs_t model(input logic w, input logic wd,
                                   input logic [15:0] a,
                                   input logic [15:0] d);
        obs_t        e;
        logic [15:0] a1;
        e   = '0;
        a1  = a + 16'd1;
        e.lat = wd ? 8'd3 : 8'd2;
        if (w) begin
            e.rd    = 16'h0000;
            e.nw    = wd ? 2'd2 : 2'd1;
            e.wa[0] = a;
            e.wv[0] = d[7:0];
            ref_mem[a] = d[7:0];
            if (wd) begin
                e.wa[1] = a1;
                e.wv[1] = d[15:8];
                ref_mem[a1] = d[15:8];
            end
        end else begin
            e.rd = wd ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
        end
        return e;
    endfunction

    task automatic preload(input logic [15:0] base);
        logic [7:0] v;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            v       = 8'($urandom);
            pl_en   = 1'b1;
            pl_addr = base + 16'(i);
            pl_data = v;
            ref_mem[base + 16'(i)] = v;
        end
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic wd,
                          input logic [15:0] a, input logic [15:0] d,
                          output obs_t o);
        int t;
        int lat;
        o = '0;
        wr_a.delete();
        wr_d.delete();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_wide  = wd;
        bus.req_addr  = a;
        bus.req_wdata = d;
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready=%b, required 1",
                     bus.req_ready);
            bus.req_valid = 1'b0;
            o.lat = 8'hFF;
            return;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = 16'($urandom);
        bus.req_write = 1'($urandom);
        bus.req_wide  = 1'($urandom);
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        o.lat = 8'(lat);
        o.rd  = bus.resp_rdata;
        o.nw  = (wr_a.size() > 3) ? 2'd3 : 2'(wr_a.size());
        for (int i = 0; i < 2; i++) begin
            if (i < wr_a.size()) begin
                o.wa[i] = wr_a[i];
                o.wv[i] = wr_d[i];
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.req_ready !== 1'b0 || bus.mem_we !== 1'b0 ||
                bus.resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl: ready=%b we=%b resp=%b, required 000",
                         bus.req_ready, bus.mem_we, bus.resp_valid);
            end
            checks++;
            if (bus.mem_addr !== 16'h0 || bus.resp_rdata !== 16'h0) begin
                errors++;
                $display("FAIL reset_data: addr=%h rdata=%h, required 0000/0000",
                         bus.mem_addr, bus.resp_rdata);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: ready=%b resp=%b, required 1/0",
                     bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic run_pair(input string name, input logic wd,
                            input logic [15:0] a, input logic [15:0] d);
        obs_t o;
        obs_t e;
        e = model(1'b1, wd, a, d);
        do_req(1'b1, wd, a, d, o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s_store: got rd=%h lat=%0d nw=%0d wa=%h wv=%h, required rd=%h lat=%0d nw=%0d wa=%h wv=%h",
                     name, o.rd, o.lat, o.nw, o.wa, o.wv,
                     e.rd, e.lat, e.nw, e.wa, e.wv);
        end
        e = model(1'b0, wd, a, 16'h0);
        do_req(1'b0, wd, a, 16'h0, o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s_load: got rd=%h lat=%0d nw=%0d, required rd=%h lat=%0d nw=%0d",
                     name, o.rd, o.lat, o.nw, e.rd, e.lat, e.nw);
        end
    endtask

    task automatic test_narrow();
        run_pair("narrow", 1'b0, 16'h1234, 16'h00A5);
    endtask

    task automatic test_wide();
        run_pair("wide", 1'b1, 16'h2000, 16'hBEEF);
    endtask

    task automatic test_wrap();
        run_pair("wrap", 1'b1, 16'hFFFF, 16'h1122);
    endtask

    task automatic test_handshake();
        logic [15:0] exp;
        exp = {ref_mem[16'h0105], ref_mem[16'h0104]};
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_wide  = 1'b1;
        bus.req_addr  = 16'h0104;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            bus.req_addr  = 16'($urandom);
            bus.req_write = 1'b1;
            bus.req_wdata = 16'($urandom);
            #1;
            checks++;
            if (bus.req_ready !== 1'b0 || bus.mem_we !== 1'b0 ||
                bus.mem_wdata !== 8'h00 ||
                bus.mem_addr !== 16'h0104 + 16'(s)) begin
                errors++;
                $display("FAIL hs_phase%0d: ready=%b we=%b wdata=%h addr=%h, required 0/0/00/%h",
                         s, bus.req_ready, bus.mem_we, bus.mem_wdata,
                         bus.mem_addr, 16'h0104 + 16'(s));
            end
        end
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
            bus.resp_rdata !== exp) begin
            errors++;
            $display("FAIL hs_resp: resp=%b ready=%b rdata=%h, required 1/0/%h",
                     bus.resp_valid, bus.req_ready, bus.resp_rdata, exp);
        end
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs[3];
        logic [15:0] exp;
        int          i;
        int          t;
        addrs = '{16'h3000, 16'h3001, 16'h3002};
        @(negedge clk);
        acc_cyc.delete();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_wide  = 1'b0;
        bus.req_addr  = addrs[0];
        i = 0;
        t = 0;
        while (i < 3 && t < 30) begin
            @(negedge clk);
            t++;
            if (bus.resp_valid === 1'b1) begin
                exp = {8'h00, ref_mem[addrs[i]]};
                checks++;
                if (bus.resp_rdata !== exp) begin
                    errors++;
                    $display("FAIL b2b_data%0d: rdata=%h, required %h",
                             i, bus.resp_rdata, exp);
                end
                i++;
                if (i < 3) bus.req_addr = addrs[i];
                else bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        checks++;
        if (i != 3 || acc_cyc.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: responses=%0d accepts=%0d, required 3/3",
                     i, acc_cyc.size());
        end else begin
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (acc_cyc[k] - acc_cyc[k-1] != 3) begin
                    errors++;
                    $display("FAIL b2b_gap%0d: gap=%0d, required 3",
                             k, acc_cyc[k] - acc_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] old1;
        logic       seen;
        old1 = ref_mem[16'h4001];
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_wide  = 1'b1;
        bus.req_addr  = 16'h4000;
        bus.req_wdata = 16'h3344;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0 ||
            bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_bus: we=%b addr=%h ready=%b resp=%b, required 0/0000/0/0",
                     bus.mem_we, bus.mem_addr, bus.req_ready, bus.resp_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        ref_mem[16'h4000] = 8'h44;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_idle: ready=%b, required 1", bus.req_ready);
        end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rmid_noresp: resp_valid seen=%b, required 0", seen);
        end
        checks++;
        if (mem[16'h4000] !== 8'h44 || mem[16'h4001] !== old1) begin
            errors++;
            $display("FAIL rmid_mem: mem=%h/%h, required 44/%h",
                     mem[16'h4000], mem[16'h4001], old1);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        obs_t        e;
        logic        w;
        logic        wd;
        logic [15:0] a;
        logic [15:0] d;
        for (int n = 0; n < 60; n++) begin
            w  = 1'($urandom);
            wd = 1'($urandom);
            a  = ($urandom_range(0, 1) != 0) ? 16'hFFF8 : 16'h0100;
            a  = a + 16'($urandom_range(0, 7));
            d  = 16'($urandom);
            e  = model(w, wd, a, d);
            do_req(w, wd, a, d, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rand%0d w=%b wide=%b a=%h: got rd=%h lat=%0d nw=%0d wa=%h wv=%h, required rd=%h lat=%0d nw=%0d wa=%h wv=%h",
                         n, w, wd, a, o.rd, o.lat, o.nw, o.wa, o.wv,
                         e.rd, e.lat, e.nw, e.wa, e.wv);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_wide  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        preload(16'hFFF0);
        preload(16'h0000);
        preload(16'h0100);
        preload(16'h1230);
        preload(16'h2000);
        preload(16'h3000);
        preload(16'h4000);
        test_reset();
        test_narrow();
        test_wide();
        test_wrap();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
